// File: rtl/cordic_arctanh_arbiter.sv
// Round-robin front end that shares one arctanh core among NREQ requesters: clamps each operand,
// issues it to the core and returns the result tagged with its requester through a latency-matched tag line.
module cordic_arctanh_arbiter #(
    parameter int unsigned        NREQ    = 4,
    parameter int unsigned        ID_W    = 2,
    parameter int unsigned        LATENCY = 18,
    parameter logic signed [31:0] CLAMP   = 32'sd58982
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          core_data,
    output logic                 core_valid,
    input  logic [31:0]          core_result,
    input  logic                 core_valid_out,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 busy,
    output logic                 err
);
    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam int unsigned FL_W  = ID_W + 5;
    localparam int unsigned TAG_W = ID_W + 1;

    typedef enum logic [0:0] {WARMUP = 1'b0, RUN = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     warm_q;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [FL_W-1:0]      inflight_q, inflight_d;
    logic [TAG_W-1:0]     tag_in_q;
    logic [TAG_W-1:0]     tag_q [LATENCY];
    logic [TAG_W-1:0]     tag_out;
    logic                 gnt_any;
    logic [ID_W-1:0]      gnt_id;
    logic signed [DW-1:0] sel_op, clamp_op;
    logic [DW-1:0]        op [NREQ];

    assign tag_out = tag_q[LATENCY-1];

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            op[k] = req_data[DW*k +: DW];
        end
    end

    // Round-robin search starting at the pointer; no grants until the core pipeline has flushed.
    always_comb begin
        int unsigned cand;
        req_ready = '0;
        gnt_any   = 1'b0;
        gnt_id    = '0;
        cand      = 0;
        if (state_q == RUN) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = 32'(ptr_q) + k;
                if (cand >= NREQ) cand = cand - NREQ;
                if (!gnt_any && req_valid[ID_W'(cand)]) begin
                    gnt_any = 1'b1;
                    gnt_id  = ID_W'(cand);
                end
            end
            req_ready[gnt_id] = gnt_any;
        end
    end

    always_comb begin
        sel_op = signed'(op[gnt_id]);
        if (sel_op > CLAMP)       clamp_op = CLAMP;
        else if (sel_op < -CLAMP) clamp_op = -CLAMP;
        else                      clamp_op = sel_op;

        ptr_d = ptr_q;
        if (gnt_any) ptr_d = (32'(gnt_id) == NREQ - 1) ? '0 : gnt_id + ID_W'(1);

        inflight_d = inflight_q + FL_W'(gnt_any) - FL_W'(rsp_valid);

        state_d = state_q;
        if (state_q == WARMUP && warm_q <= CNT_W'(1)) state_d = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WARMUP;
            warm_q     <= CNT_W'(LATENCY);
            ptr_q      <= '0;
            inflight_q <= '0;
            tag_in_q   <= '0;
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
            core_valid <= 1'b0;
            core_data  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            busy       <= 1'b1;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            busy       <= (state_d == WARMUP) || (inflight_d != '0);
            tag_q[0]   <= tag_in_q;
            for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];

            if (state_q == WARMUP) begin
                if (warm_q != '0) warm_q <= warm_q - CNT_W'(1);
            end else begin
                ptr_q <= ptr_d;
                if (gnt_any) begin
                    core_valid <= 1'b1;
                    core_data  <= clamp_op;
                    tag_in_q   <= {1'b1, gnt_id};
                end else begin
                    core_valid <= 1'b0;
                    tag_in_q   <= '0;
                end
                // Responses follow the tag even when the core's valid disagrees.
                rsp_valid <= tag_out[ID_W];
                rsp_id    <= tag_out[ID_W-1:0];
                rsp_data  <= tag_out[ID_W] ? core_result : '0;
                if (core_valid_out != tag_out[ID_W]) err <= 1'b1;
            end
        end
    end
endmodule

// File: doc/cordic_arctanh_arbiter.md
# cordic_arctanh_arbiter

Round-robin arbiter that shares one `cordic_arctanh` pipeline among NREQ requesters. Each accepted operand is clamped to the core's convergence range and issued to the core. The requester ID travels in a tag delay line that matches the core latency. Each core result is returned on a single response bus tagged with its requester ID. The block sits between the feature-extraction requesters and the arctanh core; the core is instantiated outside and wired to the `core_*` ports.

## Interface
- NREQ, 4, number of requesters (2..8)
- ID_W, 2, requester ID width; must satisfy 2^ID_W ≥ NREQ
- LATENCY, 18, core latency from `pre_vaild` edge to `post_vaild` edge
- CLAMP, 32'sd58982, saturation magnitude (0.9 in Q16.16)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_data  in  32*NREQ  signed Q16.16 operands; requester i uses bits [32i+31:32i]
- req_ready  out  NREQ  one-hot grant; at most one bit high per cycle
- core_data  out  32  operand to core `iData`
- core_valid  out  1  to core `pre_vaild`
- core_result  in  32  from core `arctanh`
- core_valid_out  in  1  from core `post_vaild`
- rsp_valid  out  1  response strobe, one cycle; no backpressure
- rsp_id  out  ID_W  requester that issued the operand
- rsp_data  out  32  arctanh result, Q16.16
- busy  out  1  high while warm-up is running or in-flight count ≠ 0
- err  out  1  sticky; core valid disagreed with tag valid

## Operation
- Reset values: req_ready=0, core_valid=0, core_data=0, rsp_valid=0, rsp_id=0, rsp_data=0, err=0, busy=1. Reset also sets the RR pointer to 0, clears the tag line and in-flight count, and loads the warm-up counter with LATENCY.
- States:
  - WARMUP: counter decrements each cycle. No grants. core_valid_out is ignored, because the core's valid shift register has no reset.
  - RUN: entered when the counter reaches 0.
  - Reset at any time (including mid-operation) returns to WARMUP and discards all in-flight work with no response.
- Arbitration in RUN, combinational:
  - Search req_valid starting at the RR pointer, wrapping modulo NREQ. The first set bit gets req_ready.
  - A transfer is req_valid[i] & req_ready[i].
  - After a transfer, pointer ← i+1 mod NREQ. With no transfer, the pointer holds.
- Issue on a transfer, registered:
  - core_data ← clamp(req_data[i]): values > CLAMP become CLAMP, values < −CLAMP become −CLAMP, otherwise unchanged.
  - core_valid ← 1 and tag_in ← {1, i}.
  - With no transfer: core_valid ← 0, tag_in ← 0, and core_data holds.
- Tag line: LATENCY-deep shift register of {valid, id}, advancing every cycle from tag_in.
- Response, registered, in RUN: rsp_valid ← tag_out.valid, rsp_id ← tag_out.id, rsp_data ← core_result.
- Error check: in RUN, if core_valid_out ≠ tag_out.valid, set err. err stays high until reset. The response still follows the tag.
- In-flight counter, width ID_W+5: +1 on transfer, −1 on rsp_valid, net 0 when both happen together. It never exceeds LATENCY+2.

## Timing
- Throughput: one operand per cycle sustained; no stall path.
- Transfer sampled at edge E:
  - core_valid/core_data high after E.
  - Core output valid after E+LATENCY.
  - rsp_valid high after E+LATENCY+1.
  - Request-to-response latency is LATENCY+1 = 19 cycles.
- The first grant is possible in the cycle after the warm-up counter hits 0, i.e. LATENCY+1 cycles after rst_n deasserts.
- Responses return in issue order. rsp_data is 0 whenever rsp_valid is 0, matching the core's zeroing.

## Test plan
- Reset mid-stream: 5 operands in flight, pulse rst_n low → no responses for them; busy=1; req_ready=0 for 18 cycles after release; err stays 0.
- Single requester: req 2 sends 0x8000 (0.5) at edge E → rsp_valid after E+19, rsp_id=2, rsp_data≈35999 (0.5493) ±8 LSB; busy drops the next cycle.
- RR fairness: all 4 req_valid held high for 12 cycles → grants 0,1,2,3 repeating, 3 each; responses arrive in the same order, back-to-back.
- Clamp: operand 0x0001_0000 (1.0) → core_data=58982; operand 0xFFFF_0000 (−1.0) → core_data=−58982; operand 0x4000 → passes unchanged.
- Pointer wrap and skip: pointer at 3, only req 1 valid → req 1 granted, pointer becomes 2; next, req 0 and req 2 valid → req 2 granted.
- Error injection: force core_valid_out=1 for one cycle with the tag invalid → err=1 next cycle and stays 1 through further traffic until reset.
